mem_stage_dmem: RTL
===================

Name: mem_stage_dmem

Overview:
- Memory-access stage of the 5-stage MIPS pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Holds the data memory and performs word, halfword and byte loads and stores, little-endian.
- Produces the load data (ReadDataM) that the MEM/WB register samples.
- Detects misaligned and reserved-size accesses, suppresses their effects, and records them in a sticky fault register.

Parameters:
- DATA_W, 32, data and address width.
- DEPTH_LOG2, 8, log2 of the number of 32-bit words (256 words = 1 KiB).
- CNT_W, 8, width of the saturating fault counter.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-low.
- ALUOutM  input  DATA_W  byte address.
- WriteDataM  input  DATA_W  store data; the sub-word is taken from the low bits.
- MemWriteM  input  1  store enable.
- MemReadM  input  1  load enable.
- MemSizeM  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- MemSignedM  input  1  1 = sign-extend sub-word loads, 0 = zero-extend.
- ErrClr  input  1  synchronous clear of the fault register.
- ReadDataM  output  DATA_W  load result (combinational).
- FaultM  output  1  current access is faulting (combinational).
- ErrValid  output  1  sticky: a fault has occurred since the last clear or reset.
- ErrAddr  output  DATA_W  byte address of the first fault since the last clear.
- ErrCount  output  CNT_W  number of faults, saturating.

Behaviour:
- Reset (RST low, asynchronous):
  - All memory words become 0.
  - ErrValid = 0, ErrAddr = 0, ErrCount = 0.
  - ReadDataM follows the rules below, so it reads 0 after reset.
  - A reset in mid-operation discards any store on that edge.
- Addressing:
  - Word index = ALUOutM[DEPTH_LOG2+1:2]. Higher address bits are ignored, so the address space wraps modulo 4*2^DEPTH_LOG2 bytes.
  - Byte lane = ALUOutM[1:0], little-endian: lane 0 = bits 7:0.
- Fault condition. A cycle faults when (MemReadM | MemWriteM) is 1 and any of these holds:
  - MemSizeM == 11;
  - MemSizeM == 01 and ALUOutM[0] == 1;
  - MemSizeM == 10 and ALUOutM[1:0] != 00.
  - FaultM = that condition.
- Store: on the rising edge with MemWriteM = 1 and FaultM = 0, write to the addressed word.
  - Byte: only lane ALUOutM[1:0] is written with WriteDataM[7:0].
  - Half: only lanes {ALUOutM[1],0} and {ALUOutM[1],1} are written with WriteDataM[15:0].
  - Word: all lanes are written.
  - Unselected lanes keep their value. A faulting store writes nothing.
- Load (combinational, zero latency, same cycle as the address):
  - MemReadM = 0 or FaultM = 1 gives ReadDataM = 0.
  - Byte: the selected byte, extended per MemSignedM.
  - Half: the selected halfword, extended per MemSignedM.
  - Word: the full word; MemSignedM is ignored.
- Read/write ordering:
  - A store becomes visible to a load in the next cycle.
  - When MemReadM and MemWriteM are both 1, the store executes and ReadDataM returns the pre-write contents.
- Fault register (rising edge, priority top-down):
  - FaultM = 1 and ErrValid = 0: ErrValid <= 1, ErrAddr <= ALUOutM.
  - FaultM = 1 and ErrValid = 1: ErrAddr holds (first-fault capture). If ErrClr is also 1 that cycle, the new fault is captured instead: ErrValid stays 1 and ErrAddr <= ALUOutM.
  - FaultM = 0 and ErrClr = 1: ErrValid <= 0, ErrAddr <= 0.
  - ErrCount increments on every faulting cycle and saturates at 2^CNT_W-1. ErrClr resets it to 0, or to 1 when ErrClr coincides with a fault.
- No stalls and no handshake. The block accepts one access per cycle.

Test Plan:
- Reset followed by a word load:
  - Stimulus: pulse RST low mid-cycle; then MemReadM=1, size 10, addr 0x40.
  - Required: ReadDataM = 0x00000000; ErrValid = 0; ErrCount = 0.
- Sub-word stores and loads:
  - Stimulus: SW 0x11223344 @0x10; SB 0xAA @0x11; SH 0x8001 @0x12.
  - Required: LW @0x10 = 0x8001AA44. LB @0x11 signed = 0xFFFFFFAA. LBU @0x11 = 0x000000AA. LH @0x12 signed = 0xFFFF8001. LHU @0x12 = 0x00008001.
- Misaligned accesses:
  - Stimulus: SW 0xDEADBEEF @0x21 (the word @0x20 holds 0x0).
  - Required: FaultM = 1 that cycle; word @0x20 still reads 0; ErrValid = 1, ErrAddr = 0x21, ErrCount = 1.
  - Then LH @0x33: ReadDataM = 0; ErrAddr stays 0x21; ErrCount = 2.
- Clear and fault in the same cycle:
  - Stimulus: ErrClr=1 together with LW @0x06.
  - Required: ErrValid = 1, ErrAddr = 0x06, ErrCount = 1.
  - A following ErrClr with no fault gives ErrValid = 0, ErrAddr = 0, ErrCount = 0.
- Address wrap and simultaneous read/write:
  - Stimulus: SW 0xCAFEBABE @0x400 (DEPTH_LOG2 = 8).
  - Required: LW @0x000 returns 0xCAFEBABE.
  - Read+write @0x8 with old value 0x1, new value 0x2: ReadDataM = 0x1 that cycle, 0x2 the next.
- Reserved size and counter saturation:
  - Stimulus: MemSizeM=11 read @0x0.
  - Required: FaultM = 1; ReadDataM = 0.
  - After 300 consecutive faulting cycles, ErrCount = 0xFF.

Source files
------------

// File: rtl/mem_stage_dmem_if.sv
// EX/MEM-to-data-memory access bus: address, store data, access controls and load/fault results.
// The master drives the access; the slave (the data memory stage) returns load data and fault state.
interface mem_stage_dmem_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
);
    logic [DATA_W-1:0] ALUOutM;
    logic [DATA_W-1:0] WriteDataM;
    logic              MemWriteM;
    logic              MemReadM;
    logic [1:0]        MemSizeM;
    logic              MemSignedM;
    logic              ErrClr;
    logic [DATA_W-1:0] ReadDataM;
    logic              FaultM;
    logic              ErrValid;
    logic [DATA_W-1:0] ErrAddr;
    logic [CNT_W-1:0]  ErrCount;

    modport master (
        output ALUOutM, WriteDataM, MemWriteM, MemReadM, MemSizeM, MemSignedM, ErrClr,
        input  ReadDataM, FaultM, ErrValid, ErrAddr, ErrCount
    );

    modport slave (
        input  ALUOutM, WriteDataM, MemWriteM, MemReadM, MemSizeM, MemSignedM, ErrClr,
        output ReadDataM, FaultM, ErrValid, ErrAddr, ErrCount
    );
endinterface

// File: rtl/mem_stage_dmem.sv
// MIPS MEM stage data memory: little-endian byte/half/word loads and stores with sticky fault capture.
// Loads are combinational (zero latency), stores commit on the CLK edge; no backpressure, one access per cycle.
module mem_stage_dmem #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int CNT_W      = 8
) (
    input  logic CLK,
    input  logic RST,
    mem_stage_dmem_if.slave bus
);
    localparam int WORDS = 1 << DEPTH_LOG2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [DATA_W-1:0]     mem [WORDS];
    logic [DEPTH_LOG2-1:0] widx;
    logic [1:0]            lane;
    logic                  access;
    logic                  fault;
    logic [DATA_W-1:0]     rword;
    logic [7:0]            rbyte;
    logic [15:0]           rhalf;
    logic [DATA_W-1:0]     rdata;
    logic [DATA_W-1:0]     wdata_rep;
    logic [3:0]            wbe;
    logic [DATA_W-1:0]     wmerged;
    logic                  store;

    logic                  err_valid;
    logic [DATA_W-1:0]     err_addr;
    logic [CNT_W-1:0]      err_count;

    // Upper address bits fall outside the array; the address space wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.ALUOutM[DATA_W-1:DEPTH_LOG2+2];

    assign widx   = bus.ALUOutM[DEPTH_LOG2+1:2];
    assign lane   = bus.ALUOutM[1:0];
    assign access = bus.MemReadM | bus.MemWriteM;
    assign rword  = mem[widx];

    always_comb begin
        fault = 1'b0;
        if (access) begin
            case (bus.MemSizeM)
                SZ_HALF: fault = lane[0];
                SZ_WORD: fault = (lane != 2'b00);
                SZ_BYTE: fault = 1'b0;
                default: fault = 1'b1;
            endcase
        end
    end

    assign store = bus.MemWriteM & ~fault;

    always_comb begin
        rbyte = rword[8*lane +: 8];
        rhalf = rword[16*lane[1] +: 16];
        rdata = '0;
        if (bus.MemReadM && !fault) begin
            case (bus.MemSizeM)
                SZ_BYTE: rdata = {{(DATA_W-8){bus.MemSignedM & rbyte[7]}}, rbyte};
                SZ_HALF: rdata = {{(DATA_W-16){bus.MemSignedM & rhalf[15]}}, rhalf};
                default: rdata = rword;
            endcase
        end
    end

    // Replicate the store sub-word across all lanes, then let the byte enables pick.
    always_comb begin
        wdata_rep = bus.WriteDataM;
        wbe       = 4'b1111;
        case (bus.MemSizeM)
            SZ_BYTE: begin
                wdata_rep = {4{bus.WriteDataM[7:0]}};
                wbe       = 4'b0001 << lane;
            end
            SZ_HALF: begin
                wdata_rep = {2{bus.WriteDataM[15:0]}};
                wbe       = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_rep = bus.WriteDataM;
                wbe       = 4'b1111;
            end
        endcase
        wmerged = rword;
        for (int i = 0; i < 4; i++) begin
            if (wbe[i]) wmerged[8*i +: 8] = wdata_rep[8*i +: 8];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else if (store) begin
            mem[widx] <= wmerged;
        end
    end

    // First-fault capture; a clear coinciding with a fault re-arms on that fault.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else begin
            if (fault) begin
                if (!err_valid || bus.ErrClr) begin
                    err_valid <= 1'b1;
                    err_addr  <= bus.ALUOutM;
                end
            end else if (bus.ErrClr) begin
                err_valid <= 1'b0;
                err_addr  <= '0;
            end

            if (bus.ErrClr) begin
                err_count <= fault ? CNT_W'(1) : '0;
            end else if (fault && err_count != '1) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

    assign bus.ReadDataM = rdata;
    assign bus.FaultM    = fault;
    assign bus.ErrValid  = err_valid;
    assign bus.ErrAddr   = err_addr;
    assign bus.ErrCount  = err_count;
endmodule
